// File: rtl/w_sram_bank.sv
// Single-port weight SRAM bank with byte-masked writes and a fixed-latency read pipeline.
// Optional per-word even parity is enabled by defining W_SRAM_PARITY_EN.
module w_sram_bank #(
    parameter int M      = 8,
    parameter int KMAX   = 1024,
    parameter int DATA_W = 32,
    parameter int BYTE_W = DATA_W / 8,
    parameter int ROW_W  = (M <= 1) ? 1 : $clog2(M),
    parameter int K_W    = (KMAX <= 1) ? 1 : $clog2(KMAX),
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              w_en,
    input  logic              w_re,
    input  logic              w_we,
    input  logic [ROW_W-1:0]  w_row,
    input  logic [K_W-1:0]    w_k,
    input  logic [DATA_W-1:0] w_wdata,
    input  logic [BYTE_W-1:0] w_wmask,
`ifdef W_SRAM_PARITY_EN
    input  logic              inj_par,
    output logic              parity_err,
`endif
    output logic [DATA_W-1:0] w_rdata,
    output logic              w_rvalid,
    output logic              addr_err
);

    if (DATA_W % 8 != 0) begin : g_bad_data_w
        $error("w_sram_bank: DATA_W must be a multiple of 8");
    end
    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
        $error("w_sram_bank: RD_LAT must be in 1..4");
    end

    localparam logic [ROW_W:0] M_L    = (ROW_W + 1)'(M);
    localparam logic [K_W:0]   KMAX_L = (K_W + 1)'(KMAX);

    logic [DATA_W-1:0] mem [M][KMAX];

    logic              in_rng;
    logic              rd_req;
    logic              wr_req;
    logic              any_req;
    logic [DATA_W-1:0] cur;
    logic [DATA_W-1:0] merged;

    logic [RD_LAT-1:0] vld;
    logic [DATA_W-1:0] dat [RD_LAT];

    assign in_rng  = ({1'b0, w_row} < M_L) && ({1'b0, w_k} < KMAX_L);
    assign rd_req  = w_en & w_re;
    assign wr_req  = w_en & w_we & in_rng;
    assign any_req = w_en & (w_re | w_we);

    // Out-of-range reads return zero rather than whatever the array aliases to
    always_comb begin
        cur    = '0;
        merged = '0;
        if (in_rng) begin
            cur = mem[w_row][w_k];
        end
        merged = cur;
        for (int b = 0; b < BYTE_W; b++) begin
            if (w_wmask[b]) begin
                merged[8*b +: 8] = w_wdata[8*b +: 8];
            end
        end
    end

`ifdef W_SRAM_PARITY_EN
    logic              mem_par [M][KMAX];
    logic [RD_LAT-1:0] pe;
    logic              pe_now;

    always_comb begin
        pe_now = 1'b0;
        if (in_rng) begin
            pe_now = (^cur) ^ mem_par[w_row][w_k];
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld      <= '0;
            addr_err <= 1'b0;
            for (int i = 0; i < RD_LAT; i++) begin
                dat[i] <= '0;
            end
`ifdef W_SRAM_PARITY_EN
            pe <= '0;
`endif
        end else begin
            addr_err <= any_req & ~in_rng;
            vld[0]   <= rd_req;
            if (rd_req) begin
                dat[0] <= cur;
            end
            // Data only advances behind a valid so w_rdata holds between pulses
            for (int i = 1; i < RD_LAT; i++) begin
                vld[i] <= vld[i-1];
                if (vld[i-1]) begin
                    dat[i] <= dat[i-1];
                end
            end
            if (wr_req) begin
                mem[w_row][w_k] <= merged;
            end
`ifdef W_SRAM_PARITY_EN
            if (rd_req) begin
                pe[0] <= pe_now;
            end
            for (int i = 1; i < RD_LAT; i++) begin
                if (vld[i-1]) begin
                    pe[i] <= pe[i-1];
                end
            end
            if (wr_req) begin
                mem_par[w_row][w_k] <= (^merged) ^ inj_par;
            end
`endif
        end
    end

    assign w_rvalid = vld[RD_LAT-1];
    assign w_rdata  = dat[RD_LAT-1];

`ifdef W_SRAM_PARITY_EN
    assign parity_err = vld[RD_LAT-1] & pe[RD_LAT-1];
`endif

endmodule

// File: tb/tb_w_sram_bank.sv
// Randomised bench for w_sram_bank against an array/queue reference model.
// Uses M=6, KMAX=24 so out-of-range rows and k values are reachable.
module tb_w_sram_bank;

    localparam int M      = 6;
    localparam int KMAX   = 24;
    localparam int DATA_W = 32;
    localparam int BYTE_W = 4;
    localparam int ROW_W  = 3;
    localparam int K_W    = 5;
    localparam int RD_LAT = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              w_en = 1'b0;
    logic              w_re = 1'b0;
    logic              w_we = 1'b0;
    logic [ROW_W-1:0]  w_row = '0;
    logic [K_W-1:0]    w_k = '0;
    logic [DATA_W-1:0] w_wdata = '0;
    logic [BYTE_W-1:0] w_wmask = '0;
    logic [DATA_W-1:0] w_rdata;
    logic              w_rvalid;
    logic              addr_err;
`ifdef W_SRAM_PARITY_EN
    logic              inj_par = 1'b0;
    logic              parity_err;
`endif

    w_sram_bank #(
        .M(M), .KMAX(KMAX), .DATA_W(DATA_W), .BYTE_W(BYTE_W),
        .ROW_W(ROW_W), .K_W(K_W), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .w_en(w_en),
        .w_re(w_re),
        .w_we(w_we),
        .w_row(w_row),
        .w_k(w_k),
        .w_wdata(w_wdata),
        .w_wmask(w_wmask),
`ifdef W_SRAM_PARITY_EN
        .inj_par(inj_par),
        .parity_err(parity_err),
`endif
        .w_rdata(w_rdata),
        .w_rvalid(w_rvalid),
        .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] d;
        logic        pe;
    } exp_t;

    logic [31:0] mm [8][32];
    logic        mbad [8][32];
    exp_t        q[$];
    logic [31:0] last_rdata = '0;
    logic        exp_err = 1'b0;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    function automatic bit inr(input int r, input int k);
        return (r < M) && (k < KMAX);
    endfunction

    // Apply current inputs for one clock and check the outputs after the edge
    task automatic cycle();
        int   r;
        int   k;
        exp_t e;
        bit   ev;
        r = int'(w_row);
        k = int'(w_k);
        exp_err = 1'b0;
        if (!rst && w_en) begin
            if (w_re) begin
                e.due = cyc + 1 + RD_LAT - 1 + 0;
                e.due = cyc + RD_LAT;
                e.d   = inr(r, k) ? mm[r][k] : 32'h0;
                e.pe  = inr(r, k) ? mbad[r][k] : 1'b0;
                q.push_back(e);
            end
            if ((w_re || w_we) && !inr(r, k)) exp_err = 1'b1;
            if (w_we && inr(r, k)) begin
                for (int b = 0; b < 4; b++) begin
                    if (w_wmask[b]) mm[r][k][8*b +: 8] = w_wdata[8*b +: 8];
                end
`ifdef W_SRAM_PARITY_EN
                mbad[r][k] = inj_par;
`endif
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        ev = (q.size() > 0) && (q[0].due == cyc);
        chk("rvalid", {31'b0, w_rvalid}, {31'b0, ev});
        if (ev) begin
            last_rdata = q[0].d;
`ifdef W_SRAM_PARITY_EN
            chk("parity_err", {31'b0, parity_err}, {31'b0, q[0].pe});
`endif
            void'(q.pop_front());
        end
`ifdef W_SRAM_PARITY_EN
        else chk("parity_idle", {31'b0, parity_err}, 32'h0);
`endif
        chk("rdata", w_rdata, last_rdata);
        chk("addr_err", {31'b0, addr_err}, {31'b0, exp_err});
    endtask

    task automatic drv(input logic en, input logic re, input logic we,
                       input int r, input int k, input logic [31:0] wd,
                       input logic [3:0] msk);
        w_en    = en;
        w_re    = re;
        w_we    = we;
        w_row   = ROW_W'(r);
        w_k     = K_W'(k);
        w_wdata = wd;
        w_wmask = msk;
        cycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drv(0, 0, 0, 0, 0, 32'h0, 4'h0);
    endtask

    initial begin
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < 32; k++) begin
                mm[r][k]   = 32'h0;
                mbad[r][k] = 1'b0;
            end
        end
        @(negedge clk);
        @(negedge clk);
        chk("rst_rvalid", {31'b0, w_rvalid}, 32'h0);
        chk("rst_rdata", w_rdata, 32'h0);
        chk("rst_addr_err", {31'b0, addr_err}, 32'h0);
        rst = 1'b0;

        for (int r = 0; r < M; r++)
            for (int k = 0; k < KMAX; k++)
                drv(1, 0, 1, r, k, $urandom, 4'hF);

        drv(1, 0, 1, 3, 17, 32'hDEADBEEF, 4'hF);
        drv(1, 1, 0, 3, 17, 32'h0, 4'h0);
        idle(RD_LAT);
        chk("deadbeef", last_rdata, 32'hDEADBEEF);

        drv(1, 0, 1, 0, 5, 32'h11223344, 4'hF);
        drv(1, 0, 1, 0, 5, 32'hAABBCCDD, 4'b0101);
        drv(1, 1, 0, 0, 5, 32'h0, 4'h0);
        idle(RD_LAT);
        chk("bytemask", last_rdata, 32'h11BB33DD);

        for (int r = 0; r < 8; r++) drv(1, 0, 1, r, 9, 32'h900 + r, 4'hF);
        for (int r = 0; r < 8; r++) drv(1, 1, 0, r, 9, 32'h0, 4'h0);
        idle(RD_LAT + 1);

        drv(1, 0, 1, 4, 4, 32'h1, 4'hF);
        drv(1, 1, 1, 4, 4, 32'h2, 4'hF);
        drv(1, 1, 0, 4, 4, 32'h0, 4'h0);
        idle(RD_LAT);
        chk("read_first_new", last_rdata, 32'h2);

        drv(1, 0, 1, 7, 3, 32'h77777777, 4'hF);
        drv(1, 1, 0, 7, 3, 32'h0, 4'h0);
        drv(1, 1, 0, 2, 30, 32'h0, 4'h0);
        idle(RD_LAT);
        chk("oor_zero", last_rdata, 32'h0);

        drv(0, 1, 1, 1, 1, 32'h5555AAAA, 4'hF);
        drv(1, 1, 0, 1, 1, 32'h0, 4'h0);
        idle(RD_LAT);

`ifdef W_SRAM_PARITY_EN
        inj_par = 1'b1;
        drv(1, 0, 1, 5, 6, 32'h0F0F0F01, 4'hF);
        inj_par = 1'b0;
        drv(1, 1, 0, 5, 6, 32'h0, 4'h0);
        idle(RD_LAT);
`endif

        for (int i = 0; i < 2000; i++) begin
            logic [3:0] op;
            op = 4'($urandom_range(0, 15));
`ifdef W_SRAM_PARITY_EN
            inj_par = ($urandom_range(0, 15) == 0);
`endif
            drv(op != 0, op[0] | op[3], op[1] | op[2], $urandom_range(0, 7),
                $urandom_range(0, 31), $urandom, 4'($urandom));
        end
`ifdef W_SRAM_PARITY_EN
        inj_par = 1'b0;
`endif
        idle(RD_LAT);

        drv(1, 1, 0, 2, 2, 32'h0, 4'h0);
        drv(1, 1, 0, 6, 2, 32'h0, 4'h0);
        chk("pre_rst_err", {31'b0, addr_err}, 32'h1);
        rst = 1'b1;
        #1;
        chk("async_rvalid", {31'b0, w_rvalid}, 32'h0);
        chk("async_rdata", w_rdata, 32'h0);
        chk("async_addr_err", {31'b0, addr_err}, 32'h0);
        q.delete();
        last_rdata = 32'h0;
        drv(1, 0, 1, 2, 2, 32'hCAFEF00D, 4'hF);
        rst = 1'b0;
        idle(RD_LAT + 2);
        drv(1, 1, 0, 2, 2, 32'h0, 4'h0);
        idle(RD_LAT);
        chk("rst_write_ignored", {31'b0, (last_rdata == 32'hCAFEF00D)}, 32'h0);

        chk("queue_drained", q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/w_sram_bank.md
Name: w_sram_bank

Overview:
Single-port weight SRAM responder: the memory side of the W-SRAM port driven by the column loaders and by a future weight writer. It stores an M x KMAX array of DATA_W-bit words, applies byte-masked writes, and returns read data with a fixed, parameterised latency through a valid-tagged pipeline. It serves as the behavioural bank model for MAC-level simulation and as the wrapper point for a hard macro.

Parameters:
M, 8, number of rows (weight tile rows)
KMAX, 1024, words per row (k dimension)
DATA_W, 32, word width in bits; must be a multiple of 8
BYTE_W, DATA_W/8, byte-enable width
ROW_W, (M<=1)?1:$clog2(M), row address width
K_W, (KMAX<=1)?1:$clog2(KMAX), k address width
RD_LAT, 1, read latency in cycles from request to w_rvalid; legal range 1..4

Ports:
clk  in  1  clock; all logic on the rising edge
rst  in  1  reset, asynchronous, active-high
w_en  in  1  port enable; with w_en=0 the cycle carries no request
w_re  in  1  read request (qualified by w_en)
w_we  in  1  write request (qualified by w_en)
w_row  in  ROW_W  row address
w_k  in  K_W  k address
w_wdata  in  DATA_W  write data
w_wmask  in  BYTE_W  byte enables; bit b covers wdata[8b+7:8b]
w_rdata  out  DATA_W  read data; meaningful only while w_rvalid=1
w_rvalid  out  1  one-cycle pulse per accepted read
addr_err  out  1  one-cycle pulse: accepted request had w_row>=M or w_k>=KMAX

Behaviour:
- Reset values: w_rdata=0, w_rvalid=0, addr_err=0. The read pipeline is cleared. The storage array is not reset; its contents are undefined until written.
- Reset asserted mid-operation: all in-flight reads are discarded and no w_rvalid is produced for them. Writes issued in the reset cycle are ignored.
- The bank accepts one request per cycle with no backpressure. Back-to-back reads on consecutive cycles produce consecutive w_rvalid pulses, in order.
- Write (w_en & w_we): on the capture edge, for each b with w_wmask[b]=1, mem[row][k] byte b is set to wdata byte b. Unmasked bytes are unchanged. w_wmask=0 is a legal no-op write.
- Read (w_en & w_re): mem[row][k] is sampled at the capture edge. w_rvalid=1 with w_rdata holding that word exactly RD_LAT cycles later (RD_LAT=1 means the following cycle).
- Read pipeline: RD_LAT-stage shift register of {valid, data}. Stage 1 is loaded at the capture edge. Between pulses, w_rdata holds its last value; it is not zeroed.
- Simultaneous w_re and w_we to the same address in one cycle: read-first. The returned data is the pre-write word, and the write still commits.
- A read issued in the cycle after a write to the same address returns the new data.
- w_re or w_we without w_en: no effect.
- Out-of-range address (row>=M or k>=KMAX; only possible when M or KMAX is not a power of 2):
  - any write is suppressed;
  - a read still produces w_rvalid at normal latency, with w_rdata=0;
  - addr_err pulses in the cycle after capture, independent of RD_LAT.
- Elaboration error if DATA_W%8!=0 or RD_LAT is outside 1..4.

Optional Feature:
Macro W_SRAM_PARITY_EN.
- Defined:
  - each word stores one extra even-parity bit, computed over the fully merged post-write word;
  - output port parity_err (1 bit, reset 0) pulses aligned with w_rvalid when the stored parity mismatches the read data;
  - test-only input inj_par (1 bit): when high during a write, the stored parity bit is inverted.
- Not defined: no parity storage, and neither port parity_err nor inj_par exists.

Test Plan:
- Basic read, RD_LAT=1: write row 3, k 17 with 0xDEADBEEF and mask 0xF, then read the same address -> w_rvalid exactly 1 cycle after the read request, w_rdata=0xDEADBEEF.
- Byte mask: write 0x11223344 (mask 0xF) to row 0, k 5, then write 0xAABBCCDD with mask 0b0101, then read -> 0x11BB33DD.
- Pipelined reads, RD_LAT=3: read rows 0..7 at k=9 on consecutive cycles, with distinct words prewritten -> 8 consecutive w_rvalid pulses starting 3 cycles after the first request, data in row order, no gaps.
- Read-first collision: address holds 0x00000001; issue w_re=w_we=1 with wdata 0x00000002 in the same cycle -> returns 0x00000001; a following read returns 0x00000002.
- Reset mid-flight, RD_LAT=4: issue 2 reads, assert rst asynchronously 2 cycles later (between clock edges) -> w_rvalid, w_rdata and addr_err all go 0 immediately; no w_rvalid after release.
- Out of range, M=6 and W_SRAM_PARITY_EN defined:
  - write to row 7 -> addr_err pulses and row 7 contents are unchanged;
  - read of row 7 -> w_rdata=0 with w_rvalid;
  - a write with inj_par=1 followed by a read of that address -> parity_err pulses aligned with w_rvalid.
